// File: rtl/sram_rd_pkg.sv
// ============================================================================
// Module  : sram_rd_pkg
// Brief   : Shared sizing constants and FSM state type for sram_block_reader.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sram_rd_pkg;

  localparam int ADDR_BITS       = 6;
  localparam int WORD_BITS       = 128;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int BLOCK_BITS      = WORDS_PER_BLOCK * WORD_BITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/flex_counter.sv
// ============================================================================
// Module  : flex_counter
// Brief   : Counts 0..ROLLOVER_VAL-1 and wraps; o_last flags the final value.
// Revision: 1.0
// ============================================================================
`default_nettype none

module flex_counter #(
  parameter int NUM_CNT_BITS = 2,
  parameter int ROLLOVER_VAL = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    i_clear,
  input  logic                    i_count_enable,
  output logic [NUM_CNT_BITS-1:0] o_count,
  output logic                    o_last
);

  logic [NUM_CNT_BITS-1:0] r_count;
  logic [NUM_CNT_BITS-1:0] w_count_next;
  logic                    w_last;

  assign w_last = (r_count == NUM_CNT_BITS'(ROLLOVER_VAL - 1));

  always_comb begin
    w_count_next = r_count;
    if (i_clear) begin
      w_count_next = '0;
    end else if (i_count_enable) begin
      w_count_next = w_last ? '0 : r_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign o_count = r_count;
  assign o_last  = w_last;

endmodule

`default_nettype wire

// File: rtl/sram_block_reader.sv
// ============================================================================
// Module  : sram_block_reader
// Brief   : Fetches WORDS_PER_BLOCK SRAM words into one block with a
//           valid/ready hand-off. Define MD4_LE_SWAP_EN to byte-reverse each
//           32-bit lane of every captured word.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_block_reader #(
  parameter int ADDR_BITS       = sram_rd_pkg::ADDR_BITS,
  parameter int WORD_BITS       = sram_rd_pkg::WORD_BITS,
  parameter int WORDS_PER_BLOCK = sram_rd_pkg::WORDS_PER_BLOCK
) (
  input  logic                                 clk,
  input  logic                                 n_rst,
  input  logic                                 start,
  input  logic [ADDR_BITS-1:0]                 base_addr,
  output logic                                 busy,
  output logic                                 sram_read_enable,
  output logic [ADDR_BITS-1:0]                 sram_address,
  input  logic [WORD_BITS-1:0]                 sram_read_data,
  output logic                                 block_valid,
  input  logic                                 block_ready,
  output logic [WORDS_PER_BLOCK*WORD_BITS-1:0] block_data,
  output logic [7:0]                           block_count
);

  import sram_rd_pkg::*;

  localparam int C_BLOCK_BITS = WORDS_PER_BLOCK * WORD_BITS;
  localparam int C_IDX_BITS   = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;

  state_t                  r_state;
  state_t                  w_next;
  logic [ADDR_BITS-1:0]    r_base;
  logic [C_BLOCK_BITS-1:0] r_block_data;
  logic [7:0]              r_block_count;
  logic [C_IDX_BITS-1:0]   w_idx;
  logic [WORD_BITS-1:0]    w_word;
  logic                    w_last;
  logic                    w_load;
  logic                    w_xfer;
  logic                    w_fetch;

  assign w_fetch = (r_state == ST_FETCH);

  flex_counter #(
    .NUM_CNT_BITS (C_IDX_BITS),
    .ROLLOVER_VAL (WORDS_PER_BLOCK)
  ) u_word_idx (
    .clk            (clk),
    .n_rst          (n_rst),
    .i_clear        (w_load),
    .i_count_enable (w_fetch),
    .o_count        (w_idx),
    .o_last         (w_last)
  );

`ifdef MD4_LE_SWAP_EN
  for (genvar l = 0; l < WORD_BITS / 32; l++) begin : g_lane
    for (genvar b = 0; b < 4; b++) begin : g_byte
      assign w_word[l*32 + b*8 +: 8] = sram_read_data[l*32 + (3-b)*8 +: 8];
    end
  end
`else
  assign w_word = sram_read_data;
`endif

  always_comb begin
    w_next           = r_state;
    w_load           = 1'b0;
    w_xfer           = 1'b0;
    busy             = 1'b1;
    sram_read_enable = 1'b0;
    sram_address     = '0;
    block_valid      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next = ST_FETCH;
          w_load = 1'b1;
        end
      end
      ST_FETCH: begin
        sram_read_enable = 1'b1;
        sram_address     = r_base + ADDR_BITS'(w_idx);
        if (w_last) begin
          w_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        block_valid = 1'b1;
        // A new start in the hand-off cycle chains straight into the next fetch.
        if (block_ready) begin
          w_xfer = 1'b1;
          if (start) begin
            w_next = ST_FETCH;
            w_load = 1'b1;
          end else begin
            w_next = ST_IDLE;
          end
        end
      end
      default: begin
        busy   = 1'b0;
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state       <= ST_IDLE;
      r_base        <= '0;
      r_block_data  <= '0;
      r_block_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_base <= base_addr;
      end
      if (w_xfer) begin
        r_block_count <= r_block_count + 8'd1;
      end
      if (w_fetch) begin
        for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
          if (w_idx == C_IDX_BITS'(k)) begin
            r_block_data[C_BLOCK_BITS-1-k*WORD_BITS -: WORD_BITS] <= w_word;
          end
        end
      end
    end
  end

  assign block_data  = r_block_data;
  assign block_count = r_block_count;

endmodule

`default_nettype wire

// File: tb/tb_sram_block_reader.sv
// ============================================================================
// Module  : tb_sram_block_reader
// Brief   : Self-checking bench for sram_block_reader against a block model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sram_block_reader;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         start;
  logic [5:0]   base_addr;
  logic         busy;
  logic         sram_read_enable;
  logic [5:0]   sram_address;
  logic [127:0] sram_read_data;
  logic         block_valid;
  logic         block_ready;
  logic [511:0] block_data;
  logic [7:0]   block_count;

  logic [127:0] mem [64];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           exp_count = 0;

  sram_block_reader dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .start            (start),
    .base_addr        (base_addr),
    .busy             (busy),
    .sram_read_enable (sram_read_enable),
    .sram_address     (sram_address),
    .sram_read_data   (sram_read_data),
    .block_valid      (block_valid),
    .block_ready      (block_ready),
    .block_data       (block_data),
    .block_count      (block_count)
  );

  always #5 clk = ~clk;

  assign sram_read_data = mem[sram_address];

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] xform(input logic [127:0] w);
    logic [127:0] r;
    r = w;
`ifdef MD4_LE_SWAP_EN
    for (int l = 0; l < 4; l++)
      for (int b = 0; b < 4; b++)
        r[l*32 + b*8 +: 8] = w[l*32 + (3-b)*8 +: 8];
`endif
    return r;
  endfunction

  // Block = words base, base+1, ... concatenated with word 0 most significant.
  function automatic logic [511:0] exp_block(input logic [5:0] base);
    logic [511:0] blk;
    logic [5:0]   a;
    blk = '0;
    for (int k = 0; k < 4; k++) begin
      a   = base + 6'(k);
      blk = (blk << 128) | 512'(xform(mem[a]));
    end
    return blk;
  endfunction

  // Called at the negedge where the first FETCH cycle is visible.
  task automatic check_fetch(input logic [5:0] base);
    logic [511:0] eb;
    eb = exp_block(base);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) begin
        start     = 1'b1;
        base_addr = 6'($urandom);
      end else begin
        start = 1'b0;
      end
      chk("fetch_busy", 512'(busy), 512'(1));
      chk("fetch_rd_en", 512'(sram_read_enable), 512'(1));
      chk("fetch_addr", 512'(sram_address), 512'(6'(base + 6'(k))));
      chk("fetch_valid_low", 512'(block_valid), 512'(0));
    end
    @(negedge clk);
    start = 1'b0;
    chk("hold_valid", 512'(block_valid), 512'(1));
    chk("hold_rd_en", 512'(sram_read_enable), 512'(0));
    chk("hold_addr", 512'(sram_address), 512'(0));
    chk("hold_data", block_data, eb);
  endtask

  task automatic issue_start(input logic [5:0] base);
    start     = 1'b1;
    base_addr = base;
    @(negedge clk);
    start = 1'b0;
    check_fetch(base);
  endtask

  task automatic stall(input int n);
    logic [511:0] held;
    held = block_data;
    for (int i = 0; i < n; i++) begin
      start     = 1'($urandom);
      base_addr = 6'($urandom);
      @(negedge clk);
      chk("stall_valid", 512'(block_valid), 512'(1));
      chk("stall_data", block_data, held);
    end
    start = 1'b0;
  endtask

  task automatic transfer(input logic chain, input logic [5:0] nbase);
    block_ready = 1'b1;
    start       = chain;
    base_addr   = nbase;
    @(negedge clk);
    block_ready = 1'b0;
    start       = 1'b0;
    exp_count   = (exp_count + 1) % 256;
    chk("xfer_count", 512'(block_count), 512'(exp_count));
    if (chain) begin
      check_fetch(nbase);
    end else begin
      chk("xfer_idle_busy", 512'(busy), 512'(0));
      chk("xfer_idle_valid", 512'(block_valid), 512'(0));
    end
  endtask

  initial begin
    logic [5:0] b;
    logic       chain;
    for (int a = 0; a < 64; a++)
      mem[a] = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 4; k++)
      mem[k] = 128'haabbccddeeff00112233445566778899 + 128'(k);

    n_rst       = 1'b0;
    start       = 1'b0;
    block_ready = 1'b0;
    base_addr   = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_valid", 512'(block_valid), 512'(0));
    chk("rst_rd_en", 512'(sram_read_enable), 512'(0));
    chk("rst_addr", 512'(sram_address), 512'(0));
    chk("rst_data", block_data, 512'(0));
    chk("rst_count", 512'(block_count), 512'(0));
    n_rst = 1'b1;
    @(negedge clk);

    // Ready while idle must not count a transfer.
    block_ready = 1'b1;
    repeat (3) @(negedge clk);
    block_ready = 1'b0;
    chk("idle_ready_count", 512'(block_count), 512'(0));
    chk("idle_ready_valid", 512'(block_valid), 512'(0));

    // Basic fetch from base 0, then backpressure.
    issue_start(6'd0);
    chk("basic_word0", 512'(block_data[511:384]), 512'(xform(mem[0])));
    stall(10);
    transfer(1'b0, 6'd0);

    // Address wrap, then back-to-back into base 4.
    issue_start(6'd62);
    transfer(1'b1, 6'd4);
    transfer(1'b0, 6'd0);

    // Randomized sequences with random stalls and chaining.
    chain = 1'b0;
    for (int it = 0; it < 12; it++) begin
      b = 6'($urandom);
      if (!chain) issue_start(b);
      stall($urandom_range(0, 3));
      chain = 1'($urandom);
      transfer(chain, 6'($urandom));
    end
    if (chain) transfer(1'b0, 6'd0);

    // Enough chained transfers to wrap block_count through 255 -> 0.
    issue_start(6'($urandom));
    for (int i = 0; i < 250; i++) transfer(1'b1, 6'($urandom));
    transfer(1'b0, 6'd0);

`ifdef MD4_LE_SWAP_EN
    mem[8] = 128'h00112233_44556677_8899aabb_ccddeeff;
    issue_start(6'd8);
    chk("swap_lane0", 512'(block_data[511:480]), 512'(32'h33221100));
    transfer(1'b0, 6'd0);
`endif

    // Asynchronous reset in the middle of a fetch.
    start     = 1'b1;
    base_addr = 6'd10;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    exp_count = 0;
    chk("midrst_busy", 512'(busy), 512'(0));
    chk("midrst_valid", 512'(block_valid), 512'(0));
    chk("midrst_rd_en", 512'(sram_read_enable), 512'(0));
    chk("midrst_addr", 512'(sram_address), 512'(0));
    chk("midrst_data", block_data, 512'(0));
    chk("midrst_count", 512'(block_count), 512'(0));
    @(negedge clk);
    n_rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("postrst_busy", 512'(busy), 512'(0));
      chk("postrst_valid", 512'(block_valid), 512'(0));
    end
    issue_start(6'd20);
    transfer(1'b0, 6'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
